// File: rtl/axi2apb_pkg.sv
// Shared types and constants for the AXI4-Lite to APB sequencer.
package axi2apb;

  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned StrbWidth = DataWidth / 8;

  // AXI response codes, same encoding as axi_pkg
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } ctrl_state_e;

  typedef struct packed {
    logic [AddrWidth-1:0] aw_addr;
    logic [2:0]           aw_prot;
    logic                 aw_valid;
    logic [DataWidth-1:0] w_data;
    logic [StrbWidth-1:0] w_strb;
    logic                 w_valid;
    logic                 b_ready;
    logic [AddrWidth-1:0] ar_addr;
    logic [2:0]           ar_prot;
    logic                 ar_valid;
    logic                 r_ready;
  } axi_req_t;

  typedef struct packed {
    logic                 aw_ready;
    logic                 w_ready;
    logic                 b_valid;
    logic [1:0]           b_resp;
    logic                 ar_ready;
    logic                 r_valid;
    logic [DataWidth-1:0] r_data;
    logic [1:0]           r_resp;
  } axi_resp_t;

  typedef struct packed {
    logic [AddrWidth-1:0] paddr;
    logic [2:0]           pprot;
    logic                 penable;
    logic                 pwrite;
    logic [DataWidth-1:0] pwdata;
    logic [StrbWidth-1:0] pstrb;
  } apb_req_t;

  typedef struct packed {
    logic                 pready;
    logic [DataWidth-1:0] prdata;
    logic                 pslverr;
  } apb_resp_t;

endpackage

// File: rtl/axi2apb_ctrl.sv
// Single-completer AXI4-Lite to APB sequencer.
//
//   state  | meaning
//   IDLE   | waiting for a request; grants write (AW+W) or read (AR), round-robin
//   SETUP  | APB setup phase: psel=1, penable=0, timeout counter cleared
//   ACCESS | APB access phase: waits for pready or the timeout
//   RESP   | B or R response held until the AXI master accepts it
module axi2apb_ctrl
  import axi2apb::*;
#(
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  axi_req_t  axi_req_i,
  output axi_resp_t axi_resp_o,
  output apb_req_t  apb_req_o,
  output logic      psel_o,
  input  apb_resp_t apb_resp_i,
  output logic      busy_o
);

  localparam int unsigned CntWidth = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(TimeoutCycles - 1);

  ctrl_state_e state_q, state_d;

  logic [AddrWidth-1:0] paddr_q;
  logic [2:0]           pprot_q;
  logic                 pwrite_q;
  logic [DataWidth-1:0] pwdata_q;
  logic [StrbWidth-1:0] pstrb_q;
  logic [DataWidth-1:0] rdata_q;
  logic [1:0]           resp_q;
  logic [CntWidth-1:0]  cnt_q;
  logic                 last_wr_q;

  logic wr_elig, rd_elig;
  logic grant_wr, grant_rd;
  logic timeout_hit;
  logic resp_done;

  assign wr_elig     = axi_req_i.aw_valid & axi_req_i.w_valid;
  assign rd_elig     = axi_req_i.ar_valid;
  assign timeout_hit = (TimeoutCycles != 0) && (cnt_q == CntLast);
  assign resp_done   = pwrite_q ? axi_req_i.b_ready : axi_req_i.r_ready;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state, grant arbitration and all outputs
  always_comb begin
    state_d    = state_q;
    grant_wr   = 1'b0;
    grant_rd   = 1'b0;
    axi_resp_o = '0;
    apb_req_o  = '0;
    psel_o     = 1'b0;
    busy_o     = (state_q != IDLE);

    // address/data/strobe hold their last values between transfers
    apb_req_o.paddr  = paddr_q;
    apb_req_o.pwdata = pwdata_q;
    apb_req_o.pstrb  = pstrb_q;

    case (state_q)
      IDLE: begin
        // readies stay low while reset is asserted even if valids are high
        if (rst_ni) begin
          grant_wr = wr_elig & (~rd_elig | ~last_wr_q);
          grant_rd = rd_elig & (~wr_elig | last_wr_q);
        end
        axi_resp_o.aw_ready = grant_wr;
        axi_resp_o.w_ready  = grant_wr;
        axi_resp_o.ar_ready = grant_rd;
        if (grant_wr || grant_rd) state_d = SETUP;
      end
      SETUP: begin
        psel_o           = 1'b1;
        apb_req_o.pwrite = pwrite_q;
        apb_req_o.pprot  = pprot_q;
        state_d          = ACCESS;
      end
      ACCESS: begin
        psel_o            = 1'b1;
        apb_req_o.penable = 1'b1;
        apb_req_o.pwrite  = pwrite_q;
        apb_req_o.pprot   = pprot_q;
        if (apb_resp_i.pready || timeout_hit) state_d = RESP;
      end
      RESP: begin
        if (pwrite_q) begin
          axi_resp_o.b_valid = 1'b1;
          axi_resp_o.b_resp  = resp_q;
        end else begin
          axi_resp_o.r_valid = 1'b1;
          axi_resp_o.r_resp  = resp_q;
          axi_resp_o.r_data  = rdata_q;
        end
        if (resp_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture on grant, response capture and timeout counting in ACCESS
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      paddr_q   <= '0;
      pprot_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= RespOkay;
      cnt_q     <= '0;
      last_wr_q <= 1'b0;
    end else begin
      if (grant_wr) begin
        paddr_q   <= axi_req_i.aw_addr;
        pprot_q   <= axi_req_i.aw_prot;
        pwrite_q  <= 1'b1;
        pwdata_q  <= axi_req_i.w_data;
        pstrb_q   <= axi_req_i.w_strb;
        last_wr_q <= 1'b1;
      end else if (grant_rd) begin
        paddr_q   <= axi_req_i.ar_addr;
        pprot_q   <= axi_req_i.ar_prot;
        pwrite_q  <= 1'b0;
        pwdata_q  <= '0;
        pstrb_q   <= '0;
        last_wr_q <= 1'b0;
      end

      if (state_q == SETUP) begin
        cnt_q <= '0;
      end else if (state_q == ACCESS) begin
        if (apb_resp_i.pready) begin
          resp_q <= apb_resp_i.pslverr ? RespSlvErr : RespOkay;
          if (!pwrite_q) rdata_q <= apb_resp_i.prdata;
        end else if (timeout_hit) begin
          // completer abandoned: report error with no data
          resp_q  <= RespSlvErr;
          rdata_q <= '0;
        end else begin
          cnt_q <= cnt_q + CntWidth'(1);
        end
      end
    end
  end

endmodule

// File: doc/axi2apb_ctrl.md
# axi2apb_ctrl

Single-completer AXI4-Lite to APB sequencer built on the `axi2apb` package types. It accepts AXI-Lite reads and writes, arbitrates between them, and drives one APB3/APB4 transfer at a time through SETUP and ACCESS phases. It returns the AXI-Lite B or R response and converts a stalled completer into SLVERR via a programmable timeout. It sits between the AXI-Lite interconnect leaf and a peripheral APB bus.

## Interface
- `TimeoutCycles`, default 256: maximum ACCESS-phase cycles before forced completion; 0 disables the timeout.
- `CntWidth`, default `$clog2(TimeoutCycles+1)` (min 1): timeout counter width; derived, not overridden.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset. Asynchronous assert, active-low.
- `axi_req_i` in `axi2apb::axi_req_t`: AXI-Lite AW/W/AR channels plus B/R ready.
- `axi_resp_o` out `axi2apb::axi_resp_t`: AXI-Lite ready signals plus B/R channels.
- `apb_req_o` out `axi2apb::apb_req_t`: APB paddr, pprot, penable, pwrite, pwdata, pstrb.
- `psel_o` out 1: APB PSEL. It is a separate port because `apb_req_t` carries no select.
- `apb_resp_i` in `axi2apb::apb_resp_t`: pready, prdata, pslverr.
- `busy_o` out 1: high in any state other than IDLE.

## Operation
- FSM states are IDLE, SETUP, ACCESS and RESP.
- **IDLE**
  - A write is eligible only when aw_valid and w_valid are both high.
  - A read is eligible when ar_valid is high.
  - If only one is eligible, grant it.
  - If both are eligible, grant the type not served last. The `last_was_write` flop resets to 0, so the first contended grant goes to the write.
  - On a write grant, pulse aw_ready and w_ready together for exactly that cycle. On a read grant, pulse ar_ready. These are the only cycles any AW/W/AR ready is high.
  - Register paddr, pprot, pwrite, pwdata and pstrb from the granted channel. For reads, pwdata=0 and pstrb=0.
  - Move to SETUP.
- **SETUP**
  - psel_o=1 and penable=0.
  - Clear the timeout counter.
  - Move to ACCESS.
- **ACCESS**
  - psel_o=1 and penable=1.
  - All APB request fields stay stable until exit.
  - On pready=1, capture prdata (reads only). Set resp to SLVERR (2'b10) if pslverr=1, else OKAY (2'b00). Move to RESP.
  - Else, if TimeoutCycles≠0 and the counter equals TimeoutCycles−1, set resp to SLVERR and rdata to 0, then move to RESP.
  - Otherwise increment the counter.
- **RESP**
  - Assert b_valid (write) or r_valid (read) with the registered resp/rdata. Hold them stable until the matching ready.
  - psel_o=0 and penable=0.
  - On the handshake, deassert valid and return to IDLE.
  - A new grant cannot happen before the following IDLE cycle.
- When not in SETUP or ACCESS, paddr, pwdata and pstrb hold their last values. pwrite, pprot, psel_o and penable are 0.
- A timed-out transfer abandons the APB bus: psel_o drops in RESP regardless of a late pready. A late pready is ignored.

## Timing
- Reset: every output is 0, i.e. all readies, b_valid, r_valid, psel_o, penable, all apb_req_o fields and busy_o. State is IDLE and the counter is 0.
- Grant at cycle T (ready pulse). SETUP at T+1. ACCESS from T+2.
- With pready at T+2, b/r_valid rises at T+3. With the AXI ready already high, the earliest next grant is T+4. Minimum is 4 cycles per transfer.
- Timeout with pready stuck low: ACCESS lasts exactly TimeoutCycles cycles, and valid rises in the following cycle.
- Reset asserted mid-transfer forces all outputs to 0 immediately, with no completion and no response.
- AW valid without W valid is never granted. A lone-arriving W never stalls a read.

## Structure
- Add to package `axi2apb`:
  - the state enum `ctrl_state_e` (IDLE, SETUP, ACCESS, RESP);
  - constants `RespOkay=2'b00` and `RespSlvErr=2'b10`, matching `axi_pkg` response encodings.
- One module. No sub-module is warranted: the round-robin is a single flop and the counter is inline.

## Test plan
- Single write: addr 0x1000_0010, data 0xDEAD_BEEF, strb 0xF; completer pready in the first ACCESS cycle. Expect psel_o at T+1 and penable at T+2, with paddr/pwdata/pstrb stable. Expect b_valid at T+3 with resp OKAY.
- Single read from 0x20: completer waits 3 cycles, then returns prdata=0x1234_5678 with pslverr=1. Expect 4 ACCESS cycles, then r_valid with data 0x1234_5678 and resp SLVERR.
- Contention: a write and a read are both valid and held continuously for 4 transfers. Expect grant order write, read, write, read, and readies only in grant cycles.
- Timeout with TimeoutCycles=4 and pready tied low on a read. Expect exactly 4 ACCESS cycles, then r_valid with resp SLVERR and data 0. Expect psel_o=0 in RESP, and a late pready ignored.
- Backpressure: b_ready held low 10 cycles. Expect b_valid and resp held stable, no new grant while the AR request is pending, then the read granted in the IDLE cycle after the handshake.
- Reset mid-ACCESS: expect psel_o, penable and all valids at 0 in the same cycle. After release, a new write completes normally.
